sd_spi_target: RTL

- Synthesizable SD-card-side SPI target. It sits directly downstream of the DRAM/SD bridge, on the far end of its MOSI/MISO link.
- Decodes CMD17 (single-block read) and CMD24 (single-block write) frames, checks CRC7 and CRC16, and returns R1 and data-response tokens with SD-mode timing.
- Backs each block with a 64-bit-wide storage port. One block is one 64-bit word, indexed by a 16-bit block address.

---
 rtl/sd_spi_target.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sd_spi_target.sv
// sd_spi_target: SD-card-side SPI target decoding CMD17/CMD24 frames against a 64-bit block store.
// Latency: R1 begins RESP_GAP cycles after the command end bit; read token follows R1 after DATA_GAP cycles.
// Backpressure: none; host must follow SD timing, mosi is ignored outside CMD/WTOKEN/WDATA.
module sd_spi_target #(
  parameter int RESP_GAP      = 8,
  parameter int DATA_GAP      = 8,
  parameter int BUSY_CYCLES   = 16,
  parameter int TOKEN_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mosi,
  output logic        miso,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  output logic        mem_re,
  input  logic [63:0] mem_rdata,
  output logic        busy,
  output logic        err
);
  localparam logic [2:0] S_IDLE = 3'd0, S_CMD = 3'd1, S_R1 = 3'd2, S_WTOKEN = 3'd3,
                         S_WDATA = 3'd4, S_DRESP = 3'd5, S_WBUSY = 3'd6, S_RDATA = 3'd7;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One shared phase counter, wide enough for the longest phase.
  localparam int CMAX = max2(max2(RESP_GAP + 7, DATA_GAP + 87),
                             max2(max2(TOKEN_TIMEOUT - 1, BUSY_CYCLES - 1), 79));
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] C_CMD_LAST  = CW'(47);
  localparam logic [CW-1:0] C_R1_PRE    = CW'(RESP_GAP - 1);
  localparam logic [CW-1:0] C_R1_FIRST  = CW'(RESP_GAP);
  localparam logic [CW-1:0] C_R1_CAP    = CW'(RESP_GAP + 1);
  localparam logic [CW-1:0] C_R1_LAST   = CW'(RESP_GAP + 7);
  localparam logic [CW-1:0] C_TOK_LAST  = CW'(TOKEN_TIMEOUT - 1);
  localparam logic [CW-1:0] C_WD_LAST   = CW'(63);
  localparam logic [CW-1:0] C_WC_LAST   = CW'(79);
  localparam logic [CW-1:0] C_DR_LAST   = CW'(7);
  localparam logic [CW-1:0] C_BUSY_LAST = CW'(BUSY_CYCLES - 1);
  localparam logic [CW-1:0] C_RD_TOK0   = CW'(DATA_GAP + 7);
  localparam logic [CW-1:0] C_RD_DAT    = CW'(DATA_GAP + 8);
  localparam logic [CW-1:0] C_RD_CRC    = CW'(DATA_GAP + 72);
  localparam logic [CW-1:0] C_RD_LAST   = CW'(DATA_GAP + 87);

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16(input logic [63:0] d);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = 63; i >= 0; i--) begin
      fb = d[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [46:0]   cmd;      // first 47 frame bits; the 48th arrives on the decode edge
  logic [7:0]    r1_sr;    // R1 and data-response transmit shifter
  logic          r1_bad;
  logic          is_wr;
  logic [6:0]    window;   // last 7 mosi samples while hunting for the write token
  logic [63:0]   rx_dat;
  logic [14:0]   rx_crc;
  logic          data_ok;
  logic [63:0]   tx_sr;
  logic [15:0]   crc_sr;

  logic [47:0] cmd_nxt;
  logic [7:0]  win_nxt;
  logic [15:0] rx_crc_nxt;
  logic [5:0]  idx;
  logic [7:0]  r1_nxt;
  logic        wcrc_ok;

  // Full-frame view on the decode edge and R1 selection in priority order.
  always_comb begin
    cmd_nxt    = {cmd, mosi};
    win_nxt    = {window, mosi};
    rx_crc_nxt = {rx_crc, mosi};
    idx        = cmd_nxt[45:40];
    wcrc_ok    = (crc16(rx_dat) == rx_crc_nxt);
    if ((crc7(cmd_nxt[47:8]) != cmd_nxt[7:1]) || !cmd_nxt[46] || !cmd_nxt[0])
      r1_nxt = 8'h08;
    else if ((idx != 6'd17) && (idx != 6'd24))
      r1_nxt = 8'h04;
    else if (cmd_nxt[39:24] != 16'h0000)
      r1_nxt = 8'h40;
    else
      r1_nxt = 8'h00;
  end

  // Serial output is a pure function of the current phase; idle-high by default.
  always_comb begin
    miso = 1'b1;
    case (state)
      S_R1:    if (cnt >= C_R1_FIRST) miso = r1_sr[7];
      S_DRESP: miso = r1_sr[7];
      S_WBUSY: miso = 1'b0;
      S_RDATA: begin
        if (cnt == C_RD_TOK0)                           miso = 1'b0;
        else if ((cnt >= C_RD_DAT) && (cnt < C_RD_CRC)) miso = tx_sr[63];
        else if (cnt >= C_RD_CRC)                       miso = crc_sr[15];
      end
      default: miso = 1'b1;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Main FSM: command capture, response sequencing and storage strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;   cnt <= '0;      cmd <= '0;      r1_sr <= '0;
      r1_bad <= 1'b0;    is_wr <= 1'b0;  window <= '0;   rx_dat <= '0;
      rx_crc <= '0;      data_ok <= 1'b0; tx_sr <= '0;   crc_sr <= '0;
      mem_addr <= '0;    mem_wdata <= '0; mem_we <= 1'b0; mem_re <= 1'b0;
      err <= 1'b0;
    end else begin
      err    <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state)
        S_IDLE: if (!mosi) begin
          state <= S_CMD;
          cmd   <= '0;
          cnt   <= CW'(1);
        end
        S_CMD: begin
          cmd <= cmd_nxt[46:0];
          if (cnt == C_CMD_LAST) begin
            state  <= S_R1;
            cnt    <= '0;
            r1_sr  <= r1_nxt;
            r1_bad <= (r1_nxt != 8'h00);
            is_wr  <= (idx == 6'd24);
            if (r1_nxt == 8'h00) mem_addr <= cmd_nxt[23:8];
          end else cnt <= cnt + 1'b1;
        end
        S_R1: begin
          if (cnt >= C_R1_FIRST) r1_sr <= {r1_sr[6:0], 1'b0};
          // Register err/mem_re one cycle early so they coincide with the first R1 bit.
          if (cnt == C_R1_PRE) begin
            err    <= r1_bad;
            mem_re <= !r1_bad && !is_wr;
          end
          if ((cnt == C_R1_CAP) && !r1_bad && !is_wr) begin
            tx_sr  <= mem_rdata;
            crc_sr <= crc16(mem_rdata);
          end
          if (cnt == C_R1_LAST) begin
            cnt    <= '0;
            window <= 7'h7F;
            state  <= r1_bad ? S_IDLE : (is_wr ? S_WTOKEN : S_RDATA);
          end else cnt <= cnt + 1'b1;
        end
        S_WTOKEN: begin
          window <= win_nxt[6:0];
          if (win_nxt == 8'hFE) begin
            state <= S_WDATA;
            cnt   <= '0;
          end else if (cnt == C_TOK_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
            err   <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        S_WDATA: begin
          if (cnt <= C_WD_LAST) rx_dat <= {rx_dat[62:0], mosi};
          else                  rx_crc <= rx_crc_nxt[14:0];
          if (cnt == C_WC_LAST) begin
            state   <= S_DRESP;
            cnt     <= '0;
            data_ok <= wcrc_ok;
            err     <= !wcrc_ok;
            r1_sr   <= wcrc_ok ? 8'h05 : 8'h0B;
          end else cnt <= cnt + 1'b1;
        end
        S_DRESP: begin
          r1_sr <= {r1_sr[6:0], 1'b0};
          if (cnt == C_DR_LAST) begin
            cnt   <= '0;
            state <= data_ok ? S_WBUSY : S_IDLE;
            if (data_ok) begin
              mem_we    <= 1'b1;
              mem_wdata <= rx_dat;
            end
          end else cnt <= cnt + 1'b1;
        end
        S_WBUSY: begin
          if (cnt == C_BUSY_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
        end
        S_RDATA: begin
          if ((cnt >= C_RD_DAT) && (cnt < C_RD_CRC)) tx_sr <= {tx_sr[62:0], 1'b0};
          if (cnt >= C_RD_CRC) crc_sr <= {crc_sr[14:0], 1'b0};
          if (cnt == C_RD_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule
